// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush with selectable stall priority and a saturating bubble counter. State changes on negedge clk.
module pipe_stage_buf #(
  parameter int              WIDTH            = 32,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0,
  parameter int              SKID             = 1,
  parameter int              FLUSH_WINS_STALL = 0,
  parameter int              CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nop,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;
  logic             flush_eff;

  // With the skid buffer, ready depends only on stored state, so the downstream stall never
  // reaches upstream combinationally; without it, ready follows out_ready directly.
  assign in_ready  = (SKID != 0) ? (state != FULL) : (out_ready | ~out_valid);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign flush_eff = flush & ((FLUSH_WINS_STALL != 0) | out_ready);

  always_ff @(negedge clk) begin
    if (reset || flush_eff) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_nop   <= 1'b1;
      out_data  <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_nop   <= 1'b0;
            out_data  <= in_data;
          end
        end
        // Without a skid buffer, accept in ONE implies emit, so the FULL branch is never taken.
        ONE: begin
          if (accept && emit) begin
            out_data <= in_data;
          end else if (accept) begin
            state     <= FULL;
            skid_data <= in_data;
          end else if (emit) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_nop   <= 1'b1;
            out_data  <= RESET_VAL;
          end
        end
        FULL: begin
          if (emit) begin
            state     <= ONE;
            out_data  <= skid_data;
            skid_data <= RESET_VAL;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out_nop   <= 1'b1;
          out_data  <= RESET_VAL;
          skid_data <= RESET_VAL;
        end
      endcase
    end
  end

  // Counts edges that start with no live payload, including stalled or flushed ones.
  always_ff @(negedge clk) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three configurations share one stimulus stream and are checked
// against a queue-based model per instance.
module tb_pipe_stage_buf;

  localparam logic [15:0] RV = 16'hDEAD;
  localparam int SKIDP[3] = '{1, 1, 0};
  localparam int FWSP[3]  = '{0, 1, 1};
  localparam int CMAX[3]  = '{15, 15, 63};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        ir[3];
  logic        ov[3];
  logic        nop[3];
  logic [15:0] od[3];
  logic [5:0]  bc[3];
  logic [3:0]  bc0, bc1;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mq[3][$];
  int          mcnt[3];
  bit          mok = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(16), .RESET_VAL(RV), .SKID(1), .FLUSH_WINS_STALL(0), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_nop(nop[0]), .bubble_cnt(bc0));

  pipe_stage_buf #(.WIDTH(16), .RESET_VAL(RV), .SKID(1), .FLUSH_WINS_STALL(1), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_nop(nop[1]), .bubble_cnt(bc1));

  pipe_stage_buf #(.WIDTH(16), .RESET_VAL(RV), .SKID(0), .FLUSH_WINS_STALL(1), .CNT_W(6)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_nop(nop[2]), .bubble_cnt(bc[2]));

  assign bc[0] = {2'b00, bc0};
  assign bc[1] = {2'b00, bc1};

  // Model update on the active edge: ready check, scoreboard pop on emit, push on accept.
  always @(negedge clk) begin
    int   occ;
    logic exp_ir;
    logic fl;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mq[i].delete();
        mcnt[i] = 0;
      end else if (mok) begin
        occ    = mq[i].size();
        exp_ir = (SKIDP[i] != 0) ? (occ < 2) : (out_ready || occ == 0);
        vectors++;
        if (ir[i] !== exp_ir) begin
          miscompares++;
          $display("[TB] FAIL in_ready inst%0d t=%0t: got %b want %b", i, $time, ir[i], exp_ir);
        end
        if (occ == 0 && mcnt[i] < CMAX[i]) mcnt[i]++;
        fl = flush && (FWSP[i] != 0 || out_ready);
        if (fl) begin
          mq[i].delete();
        end else begin
          if (occ > 0 && out_ready) begin
            vectors++;
            if (od[i] !== mq[i][0]) begin
              miscompares++;
              $display("[TB] FAIL emit_data inst%0d t=%0t: got %h want %h", i, $time, od[i], mq[i][0]);
            end
            void'(mq[i].pop_front());
          end
          if (in_valid && exp_ir) mq[i].push_back(in_data);
        end
      end
    end
    if (reset) mok = 1'b1;
  end

  // Registered outputs compared against the model away from the active edge.
  always @(posedge clk) begin
    logic        ev;
    logic [15:0] ed;
    if (mok) begin
      for (int i = 0; i < 3; i++) begin
        ev = (mq[i].size() != 0);
        ed = ev ? mq[i][0] : RV;
        vectors++;
        if (ov[i] !== ev || nop[i] !== !ev || od[i] !== ed || bc[i] !== 6'(mcnt[i])) begin
          miscompares++;
          $display("[TB] FAIL state inst%0d t=%0t: got v=%b nop=%b d=%h cnt=%0d want v=%b nop=%b d=%h cnt=%0d",
                   i, $time, ov[i], nop[i], od[i], bc[i], ev, !ev, ed, mcnt[i]);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ov[i] !== 1'b0 || nop[i] !== 1'b1 || od[i] !== RV || bc[i] !== 6'd0) begin
        miscompares++;
        $display("[TB] FAIL reset inst%0d: got v=%b nop=%b d=%h cnt=%0d want 0 1 %h 0", i, ov[i], nop[i], od[i], bc[i], RV);
      end
    end
    reset = 1'b0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bc[i] !== 6'd3) begin
        miscompares++;
        $display("[TB] FAIL idle_bubbles inst%0d: got %0d want 3", i, bc[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [15:0] vals[3] = '{16'h0100, 16'h0104, 16'h0108};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = vals[k];
      tick();
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (od[i] !== vals[k] || ov[i] !== 1'b1 || ir[i] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL stream inst%0d: got d=%h v=%b rdy=%b want %h 1 1", i, od[i], ov[i], ir[i], vals[k]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ov[i] !== 1'b0 || od[i] !== RV) begin
        miscompares++;
        $display("[TB] FAIL stream_drain inst%0d: got v=%b d=%h want 0 %h", i, ov[i], od[i], RV);
      end
    end
  endtask

  task automatic test_skid_full();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0200;
    tick();
    in_data = 16'h0204;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (ir[0] !== 1'b0 || ir[1] !== 1'b0 || od[0] !== 16'h0200) begin
      miscompares++;
      $display("[TB] FAIL skid_full: got rdy=%b/%b d=%h want 0/0 0200", ir[0], ir[1], od[0]);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (od[0] !== 16'h0204 || ov[0] !== 1'b1 || ir[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL skid_release: got d=%h v=%b rdy=%b want 0204 1 1", od[0], ov[0], ir[0]);
    end
    tick();
    vectors++;
    if (ov[0] !== 1'b0 || od[0] !== RV) begin
      miscompares++;
      $display("[TB] FAIL skid_empty: got v=%b d=%h want 0 %h", ov[0], od[0], RV);
    end
  endtask

  task automatic test_flush_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0300;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    vectors++;
    if (ov[0] !== 1'b1 || od[0] !== 16'h0300 || ov[1] !== 1'b0 || nop[1] !== 1'b1 || od[1] !== RV) begin
      miscompares++;
      $display("[TB] FAIL flush_stalled: got a=%b/%h b=%b/%b/%h want 1/0300 0/1/%h", ov[0], od[0], ov[1], nop[1], od[1], RV);
    end
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (ov[0] !== 1'b0 || nop[0] !== 1'b1 || od[0] !== RV) begin
      miscompares++;
      $display("[TB] FAIL flush_ready: got v=%b nop=%b d=%h want 0 1 %h", ov[0], nop[0], od[0], RV);
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0400;
    tick();
    in_data = 16'h0404;
    tick();
    flush = 1'b1; in_data = 16'h0408;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (ov[1] !== 1'b0 || od[1] !== RV || ir[1] !== 1'b1 || ov[0] !== 1'b1 || od[0] !== 16'h0400 || ir[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_full: got b=%b/%h/%b a=%b/%h/%b want 0/%h/1 1/0400/0", ov[1], od[1], ir[1], ov[0], od[0], ir[0], RV);
    end
    tick();
    vectors++;
    if (ov[1] !== 1'b0 || od[1] !== RV) begin
      miscompares++;
      $display("[TB] FAIL flush_discard: got v=%b d=%h want 0 %h", ov[1], od[1], RV);
    end
    out_ready = 1'b1;
    tick(3);
  endtask

  task automatic test_bubble_sat();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(20);
    vectors++;
    if (bc[0] !== 6'd15 || bc[1] !== 6'd15) begin
      miscompares++;
      $display("[TB] FAIL bubble_sat: got %0d/%0d want 15/15", bc[0], bc[1]);
    end
  endtask

  task automatic test_reset_mid_full();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0500;
    tick();
    in_data = 16'h0504;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ov[i] !== 1'b0 || nop[i] !== 1'b1 || od[i] !== RV || bc[i] !== 6'd0 || ir[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL reset_full inst%0d: got v=%b nop=%b d=%h cnt=%0d rdy=%b", i, ov[i], nop[i], od[i], bc[i], ir[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_full();
    test_flush_stall();
    test_flush_full();
    test_bubble_sat();
    test_reset_mid_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
